mmio_bridge: RTL and testbench

//  CPU-side bridge between the execute/memory stage and data memory plus N memory-mapped IO channels
//  (LED, switch, segment, UART...). Decodes the address window, drives one-hot channel selects and a

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_decoder.sv | 26 ++
 rtl/mmio_bridge.sv | 172 +++++++++++++++++
 tb/tb_mmio_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and default constants for the CPU-to-MMIO bridge.
// Channel indices name the standard peripherals hung off the IO window.
package mmio_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIoWait = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [31:0] IO_BASE_DEFAULT  = 32'hFFFF_FC00;
    localparam int unsigned CH_SHIFT_DEFAULT = 4;

    localparam int unsigned CH_LED  = 0;
    localparam int unsigned CH_SW   = 1;
    localparam int unsigned CH_SEG  = 2;
    localparam int unsigned CH_UART = 3;

endpackage

// File: rtl/mmio_decoder.sv
// Combinational IO window decode: address -> {hit, channel index}.
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int unsigned       CH_SHIFT = CH_SHIFT_DEFAULT,
    parameter int unsigned       N_CH     = 4,
    parameter int unsigned       CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [CH_W-1:0]   o_ch
);

    localparam int unsigned    SPAN_W = ADDR_W + 1;
    // One extra bit so a window ending at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] SPAN  = SPAN_W'(N_CH) << CH_SHIFT;

    logic [ADDR_W-1:0] w_offset;

    assign w_offset = i_addr - IO_BASE;
    assign o_hit    = (i_addr >= IO_BASE) && ({1'b0, w_offset} < SPAN);
    assign o_ch     = w_offset[CH_SHIFT +: CH_W];

endmodule

// File: rtl/mmio_bridge.sv
// CPU bridge to data memory and N memory-mapped IO channels; stalls the CPU
// through each IO ack handshake and reports decode misses, conflicts and timeouts.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       IO_W     = 16,
    parameter int unsigned       N_CH     = 4,
    parameter logic [ADDR_W-1:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int unsigned       CH_SHIFT = CH_SHIFT_DEFAULT,
    parameter int unsigned       SIGN_EXT = 0,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cpu_mread,
    input  logic                 i_cpu_mwrite,
    input  logic                 i_cpu_ioread,
    input  logic                 i_cpu_iowrite,
    input  logic [ADDR_W-1:0]    i_cpu_addr,
    input  logic [DATA_W-1:0]    i_cpu_wdata,
    output logic [DATA_W-1:0]    o_cpu_rdata,
    output logic                 o_cpu_stall,
    output logic                 o_bus_err,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic                 o_mem_we,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    output logic [N_CH-1:0]      o_io_cs,
    output logic                 o_io_we,
    output logic [CH_SHIFT-1:0]  o_io_addr,
    output logic [DATA_W-1:0]    o_io_wdata,
    input  logic [N_CH*IO_W-1:0] i_io_rdata,
    input  logic [N_CH-1:0]      i_io_ack
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e              r_state, w_state_nxt;
    logic [N_CH-1:0]     r_cs, w_cs_nxt;
    logic                r_we, w_we_nxt;
    logic [CH_SHIFT-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [CH_W-1:0]     r_ch, w_ch_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_err, w_err_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic                w_io_req;
    logic                w_hit;
    logic [CH_W-1:0]     w_dec_ch;
    logic                w_ack;
    logic [IO_W-1:0]     w_slice;
    logic [DATA_W-1:0]   w_ext;
    logic                w_unused_mread;

    mmio_decoder #(
        .ADDR_W   (ADDR_W),
        .IO_BASE  (IO_BASE),
        .CH_SHIFT (CH_SHIFT),
        .N_CH     (N_CH),
        .CH_W     (CH_W)
    ) u_decoder (
        .i_addr (i_cpu_addr),
        .o_hit  (w_hit),
        .o_ch   (w_dec_ch)
    );

    assign w_io_req       = i_cpu_ioread | i_cpu_iowrite;
    // dmem reads are side-effect free, so the read strobe needs no gating here.
    assign w_unused_mread = i_cpu_mread;

    assign o_mem_addr  = i_cpu_addr;
    assign o_mem_we    = i_cpu_mwrite & ~w_io_req;
    assign o_mem_wdata = o_mem_we ? i_cpu_wdata : '0;

    assign w_ack   = i_io_ack[r_ch];
    assign w_slice = i_io_rdata[32'(r_ch) * IO_W +: IO_W];
    assign w_ext   = (SIGN_EXT != 0) ? {{(DATA_W - IO_W){w_slice[IO_W-1]}}, w_slice}
                                     : {{(DATA_W - IO_W){1'b0}}, w_slice};

    assign o_cpu_stall = ((r_state == StIdle) && w_io_req) || (r_state == StIoWait);
    assign o_cpu_rdata = (r_state == StDone) ? r_rdata : (w_io_req ? '0 : i_mem_rdata);
    assign o_bus_err   = r_err;
    assign o_io_cs     = r_cs;
    assign o_io_we     = r_we;
    assign o_io_addr   = r_addr;
    assign o_io_wdata  = r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = r_cs;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_ch_nxt    = r_ch;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_io_req) begin
                    if (w_hit && !(i_cpu_ioread && i_cpu_iowrite)) begin
                        for (int k = 0; k < N_CH; k++) begin
                            w_cs_nxt[k] = (w_dec_ch == CH_W'(k));
                        end
                        w_we_nxt    = i_cpu_iowrite;
                        w_addr_nxt  = i_cpu_addr[CH_SHIFT-1:0];
                        w_wdata_nxt = i_cpu_wdata;
                        w_ch_nxt    = w_dec_ch;
                        w_state_nxt = StIoWait;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                        w_cs_nxt    = '0;
                        w_state_nxt = StDone;
                    end
                end
            end
            StIoWait: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Ack wins over a timeout landing on the same cycle.
                if (w_ack) begin
                    w_rdata_nxt = r_we ? '0 : w_ext;
                    w_cs_nxt    = '0;
                    w_state_nxt = StDone;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                    w_cs_nxt    = '0;
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_cs_nxt    = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cs    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ch    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cs    <= w_cs_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_ch    <= w_ch_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: memory-path vector table plus hand-written
// IO handshake, decode-error, timeout and mid-transaction reset sequences.
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned IOW = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned CHS = 4;
    localparam int unsigned TO  = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_mread = 1'b0, cpu_mwrite = 1'b0;
    logic              cpu_ioread = 1'b0, cpu_iowrite = 1'b0;
    logic [AW-1:0]     cpu_addr = '0;
    logic [DW-1:0]     cpu_wdata = '0;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_stall, bus_err;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic [NCH-1:0]    io_cs;
    logic              io_we;
    logic [CHS-1:0]    io_addr;
    logic [DW-1:0]     io_wdata;
    logic [NCH*IOW-1:0] io_rdata = '0;
    logic [NCH-1:0]    io_ack = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_bridge #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .IO_W     (IOW),
        .N_CH     (NCH),
        .IO_BASE  (32'hFFFF_FC00),
        .CH_SHIFT (CHS),
        .SIGN_EXT (0),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cpu_mread   (cpu_mread),
        .i_cpu_mwrite  (cpu_mwrite),
        .i_cpu_ioread  (cpu_ioread),
        .i_cpu_iowrite (cpu_iowrite),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_wdata   (cpu_wdata),
        .o_cpu_rdata   (cpu_rdata),
        .o_cpu_stall   (cpu_stall),
        .o_bus_err     (bus_err),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_io_cs       (io_cs),
        .o_io_we       (io_we),
        .o_io_addr     (io_addr),
        .o_io_wdata    (io_wdata),
        .i_io_rdata    (io_rdata),
        .i_io_ack      (io_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one IO request to completion; ack_ch < 0 means the selected channel never acks.
    task automatic do_io(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_ch, input int ack_wait,
                         input logic [15:0] ack_data, input logic [3:0] stray,
                         output int stalls, output logic [31:0] rdata, output logic err,
                         output logic [3:0] cs_first, output logic [3:0] cs_done,
                         output logic we_first, output logic [3:0] addr_first,
                         output logic [31:0] wd_first, output logic held);
        logic done;
        stalls = 0; rdata = '0; err = 1'b0; cs_first = '0; cs_done = '0;
        we_first = 1'b0; addr_first = '0; wd_first = '0; held = 1'b1; done = 1'b0;
        @(negedge clk);
        cpu_ioread = rd; cpu_iowrite = wr; cpu_addr = addr; cpu_wdata = wdata;
        io_rdata = {NCH{16'h7777}};
        if (ack_ch >= 0) io_rdata[ack_ch*IOW +: IOW] = ack_data;
        io_ack = stray;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!cpu_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (i == 1) begin
                cs_first = io_cs; we_first = io_we; addr_first = io_addr; wd_first = io_wdata;
            end else if (i > 1) begin
                if (io_cs !== cs_first || io_we !== we_first || io_wdata !== wd_first) held = 1'b0;
            end
            io_ack = stray;
            if (ack_ch >= 0 && i == ack_wait) io_ack[ack_ch] = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL io_bound: stall still high after %0d cycles, required release", stalls);
        end else begin
            rdata = cpu_rdata; err = bus_err; cs_done = io_cs;
        end
        cpu_ioread = 1'b0; cpu_iowrite = 1'b0; io_ack = '0;
        @(negedge clk);
        #1;
        check("err_pulse_end", {31'b0, bus_err}, 32'h0);
        check("idle_no_stall", {31'b0, cpu_stall}, 32'h0);
    endtask

    typedef struct {
        logic        mread;
        logic        mwrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    int          st;
    logic [31:0] rd_v;
    logic        err_v, we_v, held_v;
    logic [3:0]  cs_v, csd_v, ad_v;
    logic [31:0] wd_v;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_DEAD, 1'b1, 32'h1234_5678, 32'h0000_DEAD};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0055, 32'hCAFE_BABE, 1'b0, 32'h0, 32'hCAFE_BABE};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0BAD_F00D};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FC00, 32'h8000_0001, 32'h0000_0001, 1'b1, 32'h8000_0001, 32'h0000_0001};

        #3;
        check("rst_io_cs", {28'b0, io_cs}, 32'h0);
        check("rst_io_we", {31'b0, io_we}, 32'h0);
        check("rst_io_addr", {28'b0, io_addr}, 32'h0);
        check("rst_io_wdata", io_wdata, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            cpu_mread = vecs[v].mread; cpu_mwrite = vecs[v].mwrite;
            cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata; mem_rdata = vecs[v].mrdata;
            #1;
            check($sformatf("vec%0d_mem_we", v), {31'b0, mem_we}, {31'b0, vecs[v].exp_we});
            check($sformatf("vec%0d_mem_wdata", v), mem_wdata, vecs[v].exp_wdata);
            check($sformatf("vec%0d_mem_addr", v), mem_addr, vecs[v].addr);
            check($sformatf("vec%0d_rdata", v), cpu_rdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d_stall", v), {31'b0, cpu_stall}, 32'h0);
            check($sformatf("vec%0d_io_cs", v), {28'b0, io_cs}, 32'h0);
        end
        @(negedge clk);
        cpu_mread = 1'b0; cpu_mwrite = 1'b0; mem_rdata = 32'h1111_2222;

        // Read ch1 (switches), ack on 2nd wait; ch0 acks throughout and must be ignored.
        do_io(1'b1, 1'b0, 32'hFFFF_FC10, 32'h0, CH_SW, 2, 16'h8001, 4'b0001,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("rd_ch1_stall", st, 3);
        check("rd_ch1_rdata", rd_v, 32'h0000_8001);
        check("rd_ch1_err", {31'b0, err_v}, 32'h0);
        check("rd_ch1_cs", {28'b0, cs_v}, 32'h2);
        check("rd_ch1_we", {31'b0, we_v}, 32'h0);
        check("rd_ch1_cs_done", {28'b0, csd_v}, 32'h0);
        check("rd_ch1_held", {31'b0, held_v}, 32'h1);

        // Write ch0 (LED), ack on 4th wait; write captures 0 despite data on the bus.
        do_io(1'b0, 1'b1, 32'hFFFF_FC00, 32'h0000_00A5, CH_LED, 4, 16'hBEEF, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("wr_ch0_stall", st, 5);
        check("wr_ch0_cs", {28'b0, cs_v}, 32'h1);
        check("wr_ch0_we", {31'b0, we_v}, 32'h1);
        check("wr_ch0_wdata", wd_v, 32'h0000_00A5);
        check("wr_ch0_held", {31'b0, held_v}, 32'h1);
        check("wr_ch0_rdata", rd_v, 32'h0);
        check("wr_ch0_err", {31'b0, err_v}, 32'h0);

        // Last byte of the window: ch3, local address 0xF, zero-extended 0xFFFF.
        do_io(1'b1, 1'b0, 32'hFFFF_FC3F, 32'h0, CH_UART, 1, 16'hFFFF, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("top_ch3_stall", st, 2);
        check("top_ch3_cs", {28'b0, cs_v}, 32'h8);
        check("top_ch3_addr", {28'b0, ad_v}, 32'hF);
        check("top_ch3_rdata", rd_v, 32'h0000_FFFF);

        // Misses just above and just below the window; IDLE + DONE only.
        do_io(1'b1, 1'b0, 32'hFFFF_FC40, 32'h0, -1, 0, 16'h0, 4'b1111,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("miss_hi_stall", st, 1);
        check("miss_hi_err", {31'b0, err_v}, 32'h1);
        check("miss_hi_rdata", rd_v, 32'h0);
        check("miss_hi_cs", {28'b0, csd_v}, 32'h0);
        do_io(1'b1, 1'b0, 32'hFFFF_FBFF, 32'h0, -1, 0, 16'h0, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("miss_lo_err", {31'b0, err_v}, 32'h1);
        check("miss_lo_stall", st, 1);

        // Read and write together at a valid address is a conflict.
        do_io(1'b1, 1'b1, 32'hFFFF_FC20, 32'h0, -1, 0, 16'h0, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("conflict_err", {31'b0, err_v}, 32'h1);
        check("conflict_stall", st, 1);

        // IO request masks a simultaneous memory write.
        @(negedge clk);
        cpu_mwrite = 1'b1; cpu_iowrite = 1'b1; cpu_addr = 32'hFFFF_FC40; cpu_wdata = 32'h5555_AAAA;
        #1;
        check("mask_mem_we", {31'b0, mem_we}, 32'h0);
        check("mask_mem_wdata", mem_wdata, 32'h0);
        check("mask_stall", {31'b0, cpu_stall}, 32'h1);
        @(posedge clk);
        #1;
        check("mask_done_err", {31'b0, bus_err}, 32'h1);
        check("mask_done_rdata", cpu_rdata, 32'h0);
        check("mask_done_stall", {31'b0, cpu_stall}, 32'h0);
        @(negedge clk);
        cpu_mwrite = 1'b0; cpu_iowrite = 1'b0;

        // Timeout on ch2 while every other channel acks.
        do_io(1'b1, 1'b0, 32'hFFFF_FC24, 32'h0, -1, 0, 16'h0, 4'b1011,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("tmo_stall", st, TO + 1);
        check("tmo_err", {31'b0, err_v}, 32'h1);
        check("tmo_rdata", rd_v, 32'h0);
        check("tmo_cs_first", {28'b0, cs_v}, 32'h4);
        check("tmo_cs_done", {28'b0, csd_v}, 32'h0);

        // Ack on the very cycle the timeout would fire counts as success.
        do_io(1'b1, 1'b0, 32'hFFFF_FC28, 32'h0, CH_SEG, TO, 16'h1234, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("edge_stall", st, TO + 1);
        check("edge_err", {31'b0, err_v}, 32'h0);
        check("edge_rdata", rd_v, 32'h0000_1234);

        // Reset in the middle of IO_WAIT drops io_cs without a clock edge.
        @(negedge clk);
        cpu_ioread = 1'b1; cpu_addr = 32'hFFFF_FC3C;
        @(posedge clk);
        #1;
        check("mid_cs_before", {28'b0, io_cs}, 32'h8);
        check("mid_addr_before", {28'b0, io_addr}, 32'hC);
        #1 rst_n = 1'b0;
        #1;
        check("mid_cs_async", {28'b0, io_cs}, 32'h0);
        check("mid_addr_async", {28'b0, io_addr}, 32'h0);
        cpu_ioread = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_idle_stall", {31'b0, cpu_stall}, 32'h0);
        do_io(1'b1, 1'b0, 32'hFFFF_FC14, 32'h0, CH_SW, 1, 16'h00C3, 4'b0000,
              st, rd_v, err_v, cs_v, csd_v, we_v, ad_v, wd_v, held_v);
        check("resume_stall", st, 2);
        check("resume_rdata", rd_v, 32'h0000_00C3);
        check("resume_cs", {28'b0, cs_v}, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
